// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forward-select encodings,
// the pipeline tracking-slot layout and a small forward-priority helper.
package hazard_pkg;

    localparam int REG_W = 5;

    // Operand source for the instruction sitting in X
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_XM = 2'b01,
        FWD_MW = 2'b10
    } fwd_sel_e;

    // One tracking slot per downstream stage
    typedef struct packed {
        logic             valid;
        logic             wr;
        logic             load;
        logic [REG_W-1:0] rd;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    // The youngest producer wins: X beats M, otherwise read the register file
    function automatic fwd_sel_e fwd_pick(input logic hit_x, input logic hit_m);
        fwd_sel_e sel;
        if (hit_x) begin
            sel = FWD_XM;
        end else if (hit_m) begin
            sel = FWD_MW;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/comparator_5.sv
// Register-number comparator. 'same' is raw equality; 'snz' additionally
// requires a nonzero register, since r0 is hardwired to zero and never
// creates a dependency.
module comparator_5
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] a,
    input  logic [REG_W-1:0] b,
    output logic             same,
    output logic             snz
);

    assign same = (a == b);
    assign snz  = same && (a != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for a short in-order pipeline. Tracks what sits in
// X, M and W, detects load-use and multdiv hazards against the decode
// instruction, and produces registered forward selects for X.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [4:0] d_rd,
    input  logic       d_wr,
    input  logic       d_load,
    input  logic       d_md,
    input  logic       md_ready,
    output logic       stall,
    output logic [1:0] x_fwd_a,
    output logic [1:0] x_fwd_b,
    output logic       md_busy
);

    slot_t            x_q, x_d;
    slot_t            m_q, m_d;
    slot_t            w_q, w_d;
    logic             md_busy_q, md_busy_d;
    logic [REG_W-1:0] md_rd_q, md_rd_d;
    fwd_sel_e         x_fwd_a_q, x_fwd_a_d;
    fwd_sel_e         x_fwd_b_q, x_fwd_b_d;

    logic rs_x_same, rs_x_snz, rt_x_same, rt_x_snz;
    logic rs_m_same, rs_m_snz, rt_m_same, rt_m_snz;
    logic rs_md_same, rs_md_snz, rt_md_same, rt_md_snz;
    logic rd_md_same, rd_md_snz;

    logic rs_hit_x, rt_hit_x, rs_hit_m, rt_hit_m;
    logic load_use, md_hazard, stall_c, advance;

    // Source registers against the instruction in X
    comparator_5 u_cmp_rs_x (.a(d_rs), .b(x_q.rd), .same(rs_x_same), .snz(rs_x_snz));
    comparator_5 u_cmp_rt_x (.a(d_rt), .b(x_q.rd), .same(rt_x_same), .snz(rt_x_snz));

    // Source registers against the instruction in M
    comparator_5 u_cmp_rs_m (.a(d_rs), .b(m_q.rd), .same(rs_m_same), .snz(rs_m_snz));
    comparator_5 u_cmp_rt_m (.a(d_rt), .b(m_q.rd), .same(rt_m_same), .snz(rt_m_snz));

    // Sources and destination against the outstanding multdiv target
    comparator_5 u_cmp_rs_md (.a(d_rs), .b(md_rd_q), .same(rs_md_same), .snz(rs_md_snz));
    comparator_5 u_cmp_rt_md (.a(d_rt), .b(md_rd_q), .same(rt_md_same), .snz(rt_md_snz));
    comparator_5 u_cmp_rd_md (.a(d_rd), .b(md_rd_q), .same(rd_md_same), .snz(rd_md_snz));

    // A slot only counts as a producer when it is valid and writes its rd
    assign rs_hit_x = rs_x_snz && x_q.valid && x_q.wr;
    assign rt_hit_x = rt_x_snz && x_q.valid && x_q.wr;
    assign rs_hit_m = rs_m_snz && m_q.valid && m_q.wr;
    assign rt_hit_m = rt_m_snz && m_q.valid && m_q.wr;

    // Zero-latency stall decision from current state and decode fields
    always_comb begin
        load_use  = x_q.load && (rs_hit_x || rt_hit_x);
        md_hazard = md_busy_q && (rs_md_snz || rt_md_snz || (d_wr && rd_md_snz) || d_md);
        stall_c   = reset && d_valid && (load_use || md_hazard);
    end

    assign advance = d_valid && !stall_c;

    // Next-state for the tracking slots, multdiv scoreboard and forward selects
    always_comb begin
        x_d       = SLOT_BUBBLE;
        x_fwd_a_d = FWD_RF;
        x_fwd_b_d = FWD_RF;
        m_d       = x_q;
        w_d       = m_q;
        md_busy_d = md_busy_q;
        md_rd_d   = md_rd_q;

        if (advance) begin
            x_d.valid = 1'b1;
            // Multdiv results arrive late, so they are never offered for forwarding
            x_d.wr    = d_wr && !d_md;
            x_d.load  = d_load;
            x_d.rd    = d_rd;
            x_fwd_a_d = fwd_pick(rs_hit_x, rs_hit_m);
            x_fwd_b_d = fwd_pick(rt_hit_x, rt_hit_m);
        end

        if (advance && d_md) begin
            md_busy_d = 1'b1;
            md_rd_d   = d_rd;
        end else if (md_ready && md_busy_q) begin
            md_busy_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q       <= SLOT_BUBBLE;
            m_q       <= SLOT_BUBBLE;
            w_q       <= SLOT_BUBBLE;
            md_busy_q <= 1'b0;
            md_rd_q   <= '0;
            x_fwd_a_q <= FWD_RF;
            x_fwd_b_q <= FWD_RF;
        end else begin
            x_q       <= x_d;
            m_q       <= m_d;
            w_q       <= w_d;
            md_busy_q <= md_busy_d;
            md_rd_q   <= md_rd_d;
            x_fwd_a_q <= x_fwd_a_d;
            x_fwd_b_q <= x_fwd_b_d;
        end
    end

    assign stall   = stall_c;
    assign x_fwd_a = x_fwd_a_q;
    assign x_fwd_b = x_fwd_b_q;
    assign md_busy = md_busy_q;

    // The W slot and raw equality flags are kept for debug visibility only
    logic unused_bits;
    assign unused_bits = &{1'b0, w_q, rs_x_same, rt_x_same, rs_m_same, rt_m_same,
                           rs_md_same, rt_md_same, rd_md_same};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with a pipeline-history reference model.
module tb_hazard_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       dValid = 1'b0;
   logic [4:0] dRs = '0;
   logic [4:0] dRt = '0;
   logic [4:0] dRd = '0;
   logic       dWr = 1'b0;
   logic       dLoad = 1'b0;
   logic       dMd = 1'b0;
   logic       mdReady = 1'b0;
   logic       stall;
   logic [1:0] xFwdA;
   logic [1:0] xFwdB;
   logic       mdBusy;

   int totalChecks = 0;
   int badChecks = 0;

   hazard_ctrl dut (
      .clock    (clock),
      .reset    (reset),
      .d_valid  (dValid),
      .d_rs     (dRs),
      .d_rt     (dRt),
      .d_rd     (dRd),
      .d_wr     (dWr),
      .d_load   (dLoad),
      .d_md     (dMd),
      .md_ready (mdReady),
      .stall    (stall),
      .x_fwd_a  (xFwdA),
      .x_fwd_b  (xFwdB),
      .md_busy  (mdBusy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clock = ~clock;

   // Reference model: hist[0] is whatever entered X last cycle, hist[1]
   // whatever is in M. Forwarding depends only on the age of the youngest
   // in-flight writer of a register.
   typedef struct packed {
      logic       valid;
      logic       wr;
      logic       load;
      logic [4:0] rd;
   } instT;

   instT       hist [2];
   logic       mBusy = 1'b0;
   logic [4:0] mMdRd = '0;
   logic [1:0] mFwdA = 2'b00;
   logic [1:0] mFwdB = 2'b00;

   task automatic checkOutput(input string name, input logic [1:0] actual, input logic [1:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0d want %0d at t=%0t", name, actual, expected, $time);
      end
   endtask

   function automatic int producerAge(input logic [4:0] r);
      for (int i = 0; i < 2; i++) begin
         if (hist[i].valid && hist[i].wr && r != 5'd0 && hist[i].rd == r) return i + 1;
      end
      return 0;
   endfunction

   function automatic logic [1:0] fwdCode(input int age);
      if (age == 1) return 2'b01;
      if (age == 2) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic mdConflict(input logic [4:0] r);
      return (r != 5'd0) && (r == mMdRd);
   endfunction

   function automatic logic expectStall();
      if (!reset || !dValid) return 1'b0;
      if (hist[0].load && (producerAge(dRs) == 1 || producerAge(dRt) == 1)) return 1'b1;
      if (mBusy && (dMd || mdConflict(dRs) || mdConflict(dRt) || (dWr && mdConflict(dRd)))) return 1'b1;
      return 1'b0;
   endfunction

   // Every falling edge: compare all outputs against the model, then
   // advance the model by the rising edge that follows.
   always @(negedge clock) begin : compareProc
      logic       expStall;
      logic       adv;
      instT       entry;
      expStall = expectStall();
      checkOutput("stall", {1'b0, stall}, {1'b0, expStall});
      checkOutput("md_busy", {1'b0, mdBusy}, {1'b0, reset ? mBusy : 1'b0});
      checkOutput("x_fwd_a", xFwdA, reset ? mFwdA : 2'b00);
      checkOutput("x_fwd_b", xFwdB, reset ? mFwdB : 2'b00);
      if (!reset) begin
         hist[0] = '0;
         hist[1] = '0;
         mBusy   = 1'b0;
         mMdRd   = '0;
         mFwdA   = 2'b00;
         mFwdB   = 2'b00;
      end else begin
         adv   = dValid && !expStall;
         entry = '0;
         if (adv) begin
            entry.valid = 1'b1;
            entry.wr    = dWr && !dMd;
            entry.load  = dLoad;
            entry.rd    = dRd;
         end
         mFwdA = adv ? fwdCode(producerAge(dRs)) : 2'b00;
         mFwdB = adv ? fwdCode(producerAge(dRt)) : 2'b00;
         if (adv && dMd) begin
            mBusy = 1'b1;
            mMdRd = dRd;
         end else if (mdReady) begin
            mBusy = 1'b0;
         end
         hist[1] = hist[0];
         hist[0] = entry;
      end
   end

   // Drive one decode cycle just after the rising edge, return at the falling edge
   task automatic applyStimulus(input int v, input int rs, input int rt, input int rd,
                                input int wr, input int ld, input int md, input int rdy);
      @(posedge clock);
      #1;
      dValid  = (v != 0);
      dRs     = 5'(rs);
      dRt     = 5'(rt);
      dRd     = 5'(rd);
      dWr     = (wr != 0);
      dLoad   = (ld != 0);
      dMd     = (md != 0);
      mdReady = (rdy != 0);
      @(negedge clock);
   endtask

   task automatic nop();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Safety net so the run always ends
   initial begin
      #200000;
      badChecks++;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

   // Directed scenarios with hand-computed expectations
   initial begin
      hist[0] = '0;
      hist[1] = '0;

      // Reset state
      @(negedge clock);
      checkOutput("reset stall", {1'b0, stall}, 2'b00);
      checkOutput("reset busy", {1'b0, mdBusy}, 2'b00);
      checkOutput("reset fwd_a", xFwdA, 2'b00);
      @(posedge clock);
      #1 reset = 1'b1;

      // add r3,r1,r2 ; add r4,r3,r5 -> forward from X/M
      applyStimulus(1, 1, 2, 3, 1, 0, 0, 0);
      checkOutput("r031 producer stall", {1'b0, stall}, 2'b00);
      applyStimulus(1, 3, 5, 4, 1, 0, 0, 0);
      checkOutput("r031 consumer stall", {1'b0, stall}, 2'b00);
      nop();
      checkOutput("r031 fwd_a", xFwdA, 2'b01);
      checkOutput("r031 fwd_b", xFwdB, 2'b00);

      // add r3 ; nop ; sub r6,r1,r3 -> forward from M/W
      applyStimulus(1, 1, 2, 3, 1, 0, 0, 0);
      nop();
      applyStimulus(1, 1, 3, 6, 1, 0, 0, 0);
      checkOutput("r032 stall", {1'b0, stall}, 2'b00);
      nop();
      checkOutput("r032 fwd_b", xFwdB, 2'b10);
      checkOutput("r032 fwd_a", xFwdA, 2'b00);

      // lw r7 ; add r8,r7,r2 -> one bubble then M/W forward
      applyStimulus(1, 1, 0, 7, 1, 1, 0, 0);
      checkOutput("r033 load stall", {1'b0, stall}, 2'b00);
      applyStimulus(1, 7, 2, 8, 1, 0, 0, 0);
      checkOutput("r033 use stall", {1'b0, stall}, 2'b01);
      applyStimulus(1, 7, 2, 8, 1, 0, 0, 0);
      checkOutput("r033 retry stall", {1'b0, stall}, 2'b00);
      checkOutput("r033 bubble fwd_a", xFwdA, 2'b00);
      nop();
      checkOutput("r033 fwd_a", xFwdA, 2'b10);

      // r0 writes never create dependencies
      applyStimulus(1, 1, 2, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 5, 1, 0, 0, 0);
      checkOutput("r034 alu stall", {1'b0, stall}, 2'b00);
      applyStimulus(1, 1, 0, 0, 1, 1, 0, 0);
      checkOutput("r034 fwd_b", xFwdB, 2'b00);
      applyStimulus(1, 0, 0, 6, 1, 0, 0, 0);
      checkOutput("r034 load stall", {1'b0, stall}, 2'b00);
      nop();
      checkOutput("r034 fwd_a", xFwdA, 2'b00);

      // mul r9 ; independent add ; dependent add held until md_ready
      applyStimulus(1, 1, 2, 9, 1, 0, 1, 0);
      checkOutput("r035 mul stall", {1'b0, stall}, 2'b00);
      applyStimulus(1, 2, 3, 1, 1, 0, 0, 0);
      checkOutput("r035 indep stall", {1'b0, stall}, 2'b00);
      checkOutput("r035 busy set", {1'b0, mdBusy}, 2'b01);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 9, 2, 1, 1, 0, 0, 0);
         checkOutput("r035 dep stall", {1'b0, stall}, 2'b01);
      end
      applyStimulus(1, 9, 2, 1, 1, 0, 0, 1);
      checkOutput("r035 ready stall", {1'b0, stall}, 2'b01);
      applyStimulus(1, 9, 2, 1, 1, 0, 0, 0);
      checkOutput("r035 release stall", {1'b0, stall}, 2'b00);
      checkOutput("r035 busy clear", {1'b0, mdBusy}, 2'b00);
      nop();
      checkOutput("r035 fwd_a", xFwdA, 2'b00);

      // Fast completion: mul still in M when the consumer advances, no forward
      applyStimulus(1, 1, 2, 9, 1, 0, 1, 0);
      applyStimulus(1, 9, 2, 1, 1, 0, 0, 1);
      checkOutput("md fast stall", {1'b0, stall}, 2'b01);
      applyStimulus(1, 9, 2, 1, 1, 0, 0, 0);
      checkOutput("md fast release", {1'b0, stall}, 2'b00);
      nop();
      checkOutput("md no fwd", xFwdA, 2'b00);

      // WAW on the multdiv target, then back-to-back multdiv
      applyStimulus(1, 1, 2, 9, 1, 0, 1, 0);
      applyStimulus(1, 1, 2, 9, 1, 0, 0, 0);
      checkOutput("waw stall", {1'b0, stall}, 2'b01);
      applyStimulus(1, 1, 2, 9, 1, 0, 0, 1);
      applyStimulus(1, 1, 2, 9, 1, 0, 0, 0);
      checkOutput("waw release", {1'b0, stall}, 2'b00);
      applyStimulus(1, 1, 2, 10, 1, 0, 1, 0);
      applyStimulus(1, 3, 4, 11, 1, 0, 1, 0);
      checkOutput("md md stall", {1'b0, stall}, 2'b01);
      applyStimulus(1, 3, 4, 11, 1, 0, 1, 1);
      applyStimulus(1, 3, 4, 11, 1, 0, 1, 0);
      checkOutput("md md release", {1'b0, stall}, 2'b00);
      applyStimulus(0, 11, 11, 11, 1, 0, 1, 0);
      checkOutput("invalid no stall", {1'b0, stall}, 2'b00);
      checkOutput("md md busy", {1'b0, mdBusy}, 2'b01);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      nop();
      checkOutput("md md busy clear", {1'b0, mdBusy}, 2'b00);

      // Reset while busy with a load in X
      applyStimulus(1, 1, 2, 3, 1, 0, 0, 0);
      applyStimulus(1, 3, 1, 9, 1, 0, 1, 0);
      applyStimulus(1, 3, 0, 7, 1, 1, 0, 0);
      checkOutput("r036 lw stall", {1'b0, stall}, 2'b00);
      applyStimulus(1, 7, 9, 8, 1, 0, 0, 0);
      checkOutput("r036 pre stall", {1'b0, stall}, 2'b01);
      checkOutput("r036 pre busy", {1'b0, mdBusy}, 2'b01);
      checkOutput("r036 pre fwd_a", xFwdA, 2'b10);
      #2 reset = 1'b0;
      #1;
      checkOutput("r036 rst stall", {1'b0, stall}, 2'b00);
      checkOutput("r036 rst busy", {1'b0, mdBusy}, 2'b00);
      checkOutput("r036 rst fwd_a", xFwdA, 2'b00);
      checkOutput("r036 rst fwd_b", xFwdB, 2'b00);
      @(negedge clock);
      checkOutput("r036 held stall", {1'b0, stall}, 2'b00);
      @(posedge clock);
      #1;
      reset   = 1'b1;
      dValid  = 1'b0;
      mdReady = 1'b1;
      applyStimulus(1, 9, 2, 1, 1, 0, 0, 0);
      checkOutput("r036 after stall", {1'b0, stall}, 2'b00);
      checkOutput("r036 after busy", {1'b0, mdBusy}, 2'b00);
      nop();
      nop();

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
